// File: rtl/board_pkg.sv
// Shared definitions for the minesweeper board writer: cell status codes, command
// opcodes, board geometry, FSM states and small index/count helpers.
package board_pkg;

  localparam int BOARD_DIM = 5;
  localparam int CELLS     = 25;
  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 32;

  typedef logic [3:0] status_t;

  // 0..8 are revealed neighbour counts; the rest are special cell states
  localparam status_t ST_EMPTY   = 4'd0;
  localparam status_t ST_MAXNBR  = 4'd8;
  localparam status_t ST_MINE    = 4'd9;
  localparam status_t ST_COVERED = 4'd10;
  localparam status_t ST_FLAGGED = 4'd11;

  typedef enum logic [1:0] {
    OP_REVEAL = 2'b00,
    OP_FLAG   = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_EXEC,
    S_WRITE
  } state_e;

  function automatic logic [4:0] cell_index(input logic [2:0] x, input logic [2:0] y);
    return 5'(y) * 5'(BOARD_DIM) + 5'(x);
  endfunction

  function automatic logic [4:0] mask_popcount(input logic [CELLS-1:0] mask);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < CELLS; i++) n = n + 5'(mask[i]);
    return n;
  endfunction

endpackage

// File: rtl/board_writer_if.sv
// Command handshake, mine map and status-RAM write port of the board writer.
interface board_writer_if;
  import board_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [2:0]        cur_x;
  logic [2:0]        cur_y;
  logic [CELLS-1:0]  mine_mask;
  logic              wEn;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dataIn;
  logic              cmd_err;
  logic              game_over;
  logic              win;
  logic              busy;

  modport master (
    output cmd_valid, cmd_op, cur_x, cur_y, mine_mask,
    input  cmd_ready, wEn, addr, dataIn, cmd_err, game_over, win, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cur_x, cur_y, mine_mask,
    output cmd_ready, wEn, addr, dataIn, cmd_err, game_over, win, busy
  );

endinterface

// File: rtl/board_writer_neighbor_count.sv
// Combinational count of mines in the up-to-eight cells around (x, y); neighbours
// that fall off the board edge are skipped.
module neighbor_count
  import board_pkg::*;
(
  input  logic [CELLS-1:0] mask_i,
  input  logic [2:0]       x_i,
  input  logic [2:0]       y_i,
  output status_t          count_o
);

  always_comb begin
    int nx;
    int ny;
    count_o = '0;
    nx      = 0;
    ny      = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = int'(x_i) + dx;
        ny = int'(y_i) + dy;
        if (!(dx == 0 && dy == 0) && nx >= 0 && nx < BOARD_DIM &&
            ny >= 0 && ny < BOARD_DIM) begin
          if (mask_i[5'(ny * BOARD_DIM + nx)]) count_o = count_o + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/board_writer.sv
// Minesweeper board writer: sweeps the status RAM to "covered" and then applies
// REVEAL / FLAG / CLEAR commands, tracking cell state in a local shadow copy.
module board_writer
  import board_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  board_writer_if.slave bus
);

  state_e           state_q, state_d;
  logic             live_q;
  logic [4:0]       clrIdx_q, clrIdx_d;
  logic [1:0]       op_q;
  logic [2:0]       x_q, y_q;
  logic [CELLS-1:0] mask_q;
  logic [4:0]       pop_q, revealed_q;
  logic             gameOver_q, win_q;
  status_t          shadow_q [CELLS];
  logic [4:0]       addrHold_q;
  status_t          dataHold_q;

  logic       coordOk, legal, needWrite, accept, cmdErr, wEnNow;
  logic [4:0] cellIdx, wAddr, maskPop;
  status_t    curStatus, nbrCount, writeStatus, wStatus;

  assign coordOk   = (x_q < 3'(BOARD_DIM)) && (y_q < 3'(BOARD_DIM));
  assign legal     = coordOk && (op_q != OP_RSVD);
  assign cellIdx   = coordOk ? cell_index(x_q, y_q) : '0;
  assign curStatus = shadow_q[cellIdx];
  assign maskPop   = mask_popcount(bus.mine_mask);

  neighbor_count u_nbr (
    .mask_i  (mask_q),
    .x_i     (x_q),
    .y_i     (y_q),
    .count_o (nbrCount)
  );

  // A finished game (lost or won) freezes the board until the next CLEAR
  always_comb begin
    writeStatus = ST_COVERED;
    needWrite   = 1'b0;
    if (legal && !gameOver_q && !win_q) begin
      if (op_q == OP_REVEAL && curStatus == ST_COVERED) begin
        needWrite   = 1'b1;
        writeStatus = mask_q[cellIdx] ? ST_MINE : nbrCount;
      end else if (op_q == OP_FLAG && curStatus == ST_COVERED) begin
        needWrite   = 1'b1;
        writeStatus = ST_FLAGGED;
      end else if (op_q == OP_FLAG && curStatus == ST_FLAGGED) begin
        needWrite   = 1'b1;
        writeStatus = ST_COVERED;
      end
    end
  end

  // live_q holds everything quiet until the first clock after reset release
  always_comb begin
    state_d  = state_q;
    clrIdx_d = clrIdx_q;
    wEnNow   = 1'b0;
    wAddr    = '0;
    wStatus  = ST_EMPTY;
    accept   = 1'b0;
    cmdErr   = 1'b0;
    if (live_q) begin
      unique case (state_q)
        S_CLEAR: begin
          wEnNow  = 1'b1;
          wAddr   = clrIdx_q;
          wStatus = ST_COVERED;
          if (clrIdx_q == 5'(CELLS - 1)) begin
            clrIdx_d = '0;
            state_d  = S_IDLE;
          end else begin
            clrIdx_d = clrIdx_q + 5'd1;
          end
        end
        S_IDLE: begin
          if (bus.cmd_valid) begin
            accept  = 1'b1;
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          if (!legal) begin
            cmdErr  = 1'b1;
            state_d = S_IDLE;
          end else if (op_q == OP_CLEAR) begin
            clrIdx_d = '0;
            state_d  = S_CLEAR;
          end else if (needWrite) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WRITE: begin
          wEnNow  = 1'b1;
          wAddr   = cellIdx;
          wStatus = writeStatus;
          state_d = S_IDLE;
        end
        default: state_d = S_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_CLEAR;
      live_q     <= 1'b0;
      clrIdx_q   <= '0;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      mask_q     <= '0;
      pop_q      <= '0;
      revealed_q <= '0;
      gameOver_q <= 1'b0;
      win_q      <= 1'b0;
      addrHold_q <= '0;
      dataHold_q <= '0;
      for (int i = 0; i < CELLS; i++) shadow_q[i] <= ST_COVERED;
    end else begin
      live_q   <= 1'b1;
      state_q  <= state_d;
      clrIdx_q <= clrIdx_d;
      if (accept) begin
        op_q <= bus.cmd_op;
        x_q  <= bus.cur_x;
        y_q  <= bus.cur_y;
      end
      if (wEnNow) begin
        addrHold_q       <= wAddr;
        dataHold_q       <= wStatus;
        shadow_q[wAddr]  <= wStatus;
      end
      // The mask sampled on the last sweep cycle is the one play uses
      if (live_q && state_q == S_CLEAR) begin
        mask_q     <= bus.mine_mask;
        pop_q      <= maskPop;
        revealed_q <= '0;
        gameOver_q <= 1'b0;
        win_q      <= (clrIdx_q == 5'(CELLS - 1)) && (maskPop == 5'(CELLS));
      end
      if (live_q && state_q == S_WRITE && op_q == OP_REVEAL) begin
        if (mask_q[cellIdx]) begin
          gameOver_q <= 1'b1;
        end else begin
          revealed_q <= revealed_q + 5'd1;
          if (revealed_q + 5'd1 == 5'(CELLS) - pop_q) win_q <= 1'b1;
        end
      end
    end
  end

  assign bus.wEn       = wEnNow;
  assign bus.addr      = {{(ADDR_W-5){1'b0}}, (wEnNow ? wAddr : addrHold_q)};
  assign bus.dataIn    = {{(DATA_W-4){1'b0}}, (wEnNow ? wStatus : dataHold_q)};
  assign bus.cmd_ready = live_q && (state_q == S_IDLE);
  assign bus.busy      = live_q && (state_q != S_IDLE);
  assign bus.cmd_err   = cmdErr;
  assign bus.game_over = gameOver_q;
  assign bus.win       = win_q;

endmodule

// File: tb/tb_board_writer.sv
// Randomised scoreboard bench for board_writer: a board-level model predicts every
// RAM write and error pulse, and a negedge monitor checks them as they appear.
module tb_board_writer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  board_writer_if bus ();

  board_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit isErr;
    int addr;
    int data;
  } exp_t;

  exp_t expQ[$];
  int   checks     = 0;
  int   errors     = 0;
  int   writesSeen = 0;

  // Reference board: one status per cell, mine list and game flags
  int          mStatus [25];
  int          mMine   [25];
  int          mPop;
  int          mRevealed;
  bit          mGameOver;
  bit          mWin;
  logic [24:0] mineMask;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  function automatic int neighbours(input int x, input int y);
    int n = 0;
    for (int r = y - 1; r <= y + 1; r++)
      for (int c = x - 1; c <= x + 1; c++)
        if ((r != y || c != x) && r >= 0 && r < 5 && c >= 0 && c < 5 && mMine[r*5+c] != 0)
          n++;
    return n;
  endfunction

  function automatic void pushWrite(input int addr, input int data);
    exp_t e;
    e.isErr = 1'b0;
    e.addr  = addr;
    e.data  = data;
    expQ.push_back(e);
  endfunction

  function automatic void modelClear(input logic [24:0] mask);
    mPop = 0;
    for (int i = 0; i < 25; i++) begin
      mMine[i]   = mask[i] ? 1 : 0;
      mPop      += mMine[i];
      mStatus[i] = 10;
      pushWrite(i, 10);
    end
    mRevealed = 0;
    mGameOver = 1'b0;
    mWin      = (mPop == 25);
  endfunction

  // Returns the number of cycles until cmd_ready comes back
  function automatic int modelCommand(input int op, input int x, input int y);
    exp_t e;
    int   idx;
    int   val;
    if (x > 4 || y > 4 || op == 3) begin
      e.isErr = 1'b1;
      e.addr  = 0;
      e.data  = 0;
      expQ.push_back(e);
      return 2;
    end
    if (op == 2) begin
      modelClear(mineMask);
      return 27;
    end
    if (mGameOver || mWin) return 2;
    idx = y * 5 + x;
    if (op == 0) begin
      if (mStatus[idx] != 10) return 2;
      val = (mMine[idx] != 0) ? 9 : neighbours(x, y);
      pushWrite(idx, val);
      mStatus[idx] = val;
      if (val == 9) mGameOver = 1'b1;
      else begin
        mRevealed++;
        if (mRevealed == 25 - mPop) mWin = 1'b1;
      end
      return 3;
    end
    if (mStatus[idx] == 10 || mStatus[idx] == 11) begin
      val = (mStatus[idx] == 10) ? 11 : 10;
      pushWrite(idx, val);
      mStatus[idx] = val;
      return 3;
    end
    return 2;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.wEn === 1'b1) begin
      writesSeen++;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL write: got addr %0d data %0d, required no write", bus.addr, bus.dataIn);
      end else begin
        e = expQ.pop_front();
        if (e.isErr || e.addr != int'(bus.addr) || e.data != int'(bus.dataIn)) begin
          errors++;
          $display("[TB] FAIL write: got addr %0d data %0d, required %s addr %0d data %0d",
                   bus.addr, bus.dataIn, e.isErr ? "cmd_err not write" : "write", e.addr, e.data);
        end
      end
    end
    if (bus.cmd_err === 1'b1) begin
      checks++;
      if (expQ.size() == 0 || !expQ[0].isErr) begin
        errors++;
        $display("[TB] FAIL cmd_err: got pulse, required %s", expQ.size() == 0 ? "nothing" : "a write");
      end else begin
        e = expQ.pop_front();
      end
    end
  end

  task automatic setMask(input logic [24:0] m);
    mineMask      = m;
    bus.mine_mask = m;
  endtask

  task automatic releaseReset();
    int lat;
    modelClear(mineMask);
    writesSeen = 0;
    @(negedge clk);
    reset = 1'b1;
    lat   = 0;
    while (!bus.cmd_ready && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("sweep ready", int'(bus.cmd_ready), 1);
    checkOutput("sweep writes", writesSeen, 25);
    checkOutput("sweep game_over", int'(bus.game_over), int'(mGameOver));
    checkOutput("sweep win", int'(bus.win), int'(mWin));
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] x, input logic [2:0] y);
    int expLat;
    int lat;
    int guard;
    @(negedge clk);
    bus.cmd_op    = op;
    bus.cur_x     = x;
    bus.cur_y     = y;
    bus.cmd_valid = 1'b1;
    guard = 0;
    while (!bus.cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.cmd_ready) begin
      checkOutput("cmd_ready timeout", int'(bus.cmd_ready), 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    expLat = modelCommand(int'(op), int'(x), int'(y));
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    checkOutput("busy", int'(bus.busy), 1);
    while (!bus.cmd_ready && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("ready latency", lat, expLat);
    checkOutput("game_over", int'(bus.game_over), int'(mGameOver));
    checkOutput("win", int'(bus.win), int'(mWin));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int order [25];
    int j;
    int tmp;
    int sel;
    int guard;
    int snap;

    reset         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cur_x     = '0;
    bus.cur_y     = '0;
    setMask(25'h0000001);
    repeat (3) @(negedge clk);
    checkOutput("reset wEn", int'(bus.wEn), 0);
    checkOutput("reset cmd_ready", int'(bus.cmd_ready), 0);
    checkOutput("reset cmd_err", int'(bus.cmd_err), 0);
    checkOutput("reset busy", int'(bus.busy), 0);
    checkOutput("reset game_over", int'(bus.game_over), 0);
    checkOutput("reset win", int'(bus.win), 0);
    checkOutput("reset addr", int'(bus.addr), 0);
    checkOutput("reset dataIn", int'(bus.dataIn), 0);

    $display("[TB] directed scenarios");
    releaseReset();
    applyStimulus(2'b00, 3'd1, 3'd1);
    applyStimulus(2'b01, 3'd4, 3'd4);
    applyStimulus(2'b01, 3'd4, 3'd4);
    applyStimulus(2'b00, 3'd4, 3'd4);
    applyStimulus(2'b01, 3'd2, 3'd2);
    applyStimulus(2'b00, 3'd2, 3'd2);
    applyStimulus(2'b00, 3'd5, 3'd0);
    applyStimulus(2'b11, 3'd1, 3'd1);
    applyStimulus(2'b01, 3'd0, 3'd7);

    setMask(25'h0001000);
    applyStimulus(2'b10, 3'd0, 3'd0);
    setMask(25'h1FFFFFF);
    applyStimulus(2'b00, 3'd2, 3'd2);
    applyStimulus(2'b00, 3'd0, 3'd0);
    applyStimulus(2'b01, 3'd0, 3'd0);

    $display("[TB] empty board, shuffled reveals");
    setMask(25'h0);
    applyStimulus(2'b10, 3'd0, 3'd0);
    for (int i = 0; i < 25; i++) order[i] = i;
    for (int i = 24; i > 0; i--) begin
      j        = $urandom_range(0, i);
      tmp      = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 25; i++) applyStimulus(2'b00, 3'(order[i] % 5), 3'(order[i] / 5));
    applyStimulus(2'b01, 3'd3, 3'd3);

    $display("[TB] full board");
    setMask(25'h1FFFFFF);
    applyStimulus(2'b10, 3'd0, 3'd0);
    applyStimulus(2'b00, 3'd0, 3'd0);

    $display("[TB] random play");
    for (int r = 0; r < 5; r++) begin
      setMask(25'($urandom & $urandom));
      applyStimulus(2'b10, 3'd0, 3'd0);
      setMask(25'($urandom));
      for (int k = 0; k < 30; k++) begin
        sel = $urandom_range(0, 19);
        applyStimulus(sel < 11 ? 2'b00 : (sel < 18 ? 2'b01 : (sel == 18 ? 2'b11 : 2'b10)),
                      3'($urandom_range(0, 5)), 3'($urandom_range(0, 5)));
      end
    end

    $display("[TB] reset abort mid-sweep");
    @(negedge clk);
    reset = 1'b0;
    setMask(25'h0000003);
    modelClear(mineMask);
    writesSeen = 0;
    @(negedge clk);
    reset = 1'b1;
    guard = 0;
    while (writesSeen < 10 && guard < 60) begin
      @(posedge clk);
      guard++;
    end
    checkOutput("writes before abort", writesSeen, 10);
    #1 reset = 1'b0;
    #1;
    checkOutput("abort wEn", int'(bus.wEn), 0);
    checkOutput("abort addr", int'(bus.addr), 0);
    checkOutput("abort dataIn", int'(bus.dataIn), 0);
    checkOutput("abort busy", int'(bus.busy), 0);
    expQ.delete();
    snap = writesSeen;
    repeat (4) @(negedge clk);
    checkOutput("writes during reset", writesSeen, snap);
    releaseReset();
    applyStimulus(2'b00, 3'd2, 3'd0);
    applyStimulus(2'b00, 3'd1, 3'd0);

    repeat (3) @(negedge clk);
    checkOutput("pending expectations", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_writer.md
BOARD_WRITER -- requirements
Module: board_writer

Interface
REQ-001 clk  input  1  system clock (100 MHz); all state changes on the rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 cmd_valid  input  1  command request; held until accepted.
REQ-004 cmd_ready  output  1  high when a command can be accepted; transfer occurs when cmd_valid && cmd_ready.
REQ-005 cmd_op  input  2  command: 00 REVEAL, 01 FLAG toggle, 10 CLEAR, 11 reserved (treated as invalid).
REQ-006 cur_x / cur_y  input  3 each  target cell column/row, legal range 0..4.
REQ-007 mine_mask  input  25  mine map; bit 5*y+x set = mine.
REQ-008 wEn / addr / dataIn  output  1 / 12 / 32  block-status RAM write port; addr = 5*y+x zero-extended; dataIn = {28'b0, status}.
REQ-009 cmd_err  output  1  one-cycle pulse on an accepted command with illegal coordinates or reserved op.
REQ-010 game_over / win / busy  output  1 each  mine revealed / all safe cells revealed / FSM not in IDLE.

Function
REQ-011 Status codes: 0..8 revealed with that neighbour-mine count; 9 revealed mine; 10 covered; 11 flagged.
REQ-012 An internal 25 x 4-bit shadow array holds the status last written for each cell; the RAM is never read.
REQ-013 FSM states: CLEAR, IDLE, EXEC, WRITE; cmd_ready = 1 only in IDLE.
REQ-014 CLEAR: over 25 consecutive cycles, write status 10 to addr 0..24 in ascending order (wEn = 1 each cycle); set shadow to 10; latch mine_mask and its popcount; zero the revealed counter; clear game_over and win; then go to IDLE.
REQ-015 Acceptance in cycle N latches op and coordinates, and the FSM enters EXEC in cycle N+1.
REQ-016 EXEC with illegal coordinates (x > 4 or y > 4) or op 11: pulse cmd_err, perform no write, and return to IDLE in cycle N+2.
REQ-017 EXEC with op CLEAR enters CLEAR, so writes occupy cycles N+2..N+26 and cmd_ready returns in cycle N+27.
REQ-018 REVEAL of a covered cell: the status is 9 if the cell is a mine, otherwise the count of mines among up to 8 neighbours, with off-board neighbours ignored.
REQ-019 REVEAL of a covered mine sets game_over.
REQ-020 REVEAL of a covered safe cell increments the revealed counter (5 bits).
REQ-021 REVEAL of a flagged or already-revealed cell performs no write.
REQ-022 FLAG changes covered (10) to flagged (11) and flagged (11) to covered (10); FLAG of a revealed cell performs no write.
REQ-023 Any required write is a single wEn cycle in WRITE (cycle N+2), and cmd_ready returns in cycle N+3; when no write is required, the FSM returns from EXEC straight to IDLE and cmd_ready returns in cycle N+2.
REQ-024 win is set in the cycle after the write at which revealed counter == 25 - latched popcount, provided game_over is 0.
REQ-025 While game_over or win is set, REVEAL and FLAG are accepted but perform no write; only CLEAR restarts play.
REQ-026 A popcount of 0 makes every reveal safe, and win follows the 25th reveal.
REQ-027 A popcount of 25 sets win at the end of CLEAR.
REQ-028 wEn is 0 in all cycles except those stated above; addr and dataIn hold their last values when wEn = 0.
REQ-029 mine_mask changes after CLEAR have no effect until the next CLEAR.

Reset
REQ-030 While reset = 0: wEn, cmd_ready, cmd_err, game_over, win and busy are 0, and addr and dataIn are 0.
REQ-031 On reset release, the FSM enters CLEAR at write index 0 and performs the full 25-cycle sweep before first asserting cmd_ready.
REQ-032 Reset asserted mid-sweep or mid-command aborts immediately with no further writes; the next release restarts the sweep from index 0.

Structure
REQ-033 Shared package board_pkg holds: status codes (0..11), op codes, BOARD_DIM = 5, CELLS = 25, ADDR_W = 12, DATA_W = 32, and the FSM state enumeration.
REQ-034 Sub-module neighbor_count (combinational): inputs are the latched mask and x/y; the output is a 4-bit neighbour-mine count with edge and corner clipping.

Verification
REQ-035 Release reset with mine_mask = 25'h0000001 -> wEn high for 25 cycles with addr 0..24 and dataIn 10, then cmd_ready = 1 and win = 0.
REQ-036 Mask bit 0 only, REVEAL (1,1) accepted in cycle N -> cycle N+2 wEn = 1, addr 6, dataIn 1; cmd_ready = 1 in cycle N+3.
REQ-037 FLAG (4,4), FLAG (4,4), then REVEAL (4,4) -> writes 11, then 10, then 0 at addr 24.
REQ-038 FLAG (2,2), then REVEAL (2,2) -> the reveal produces no write and cmd_ready returns at N+2.
REQ-039 Mask bit 12, REVEAL (2,2) -> dataIn 9 and game_over = 1; a subsequent REVEAL (0,0) produces no write.
REQ-040 REVEAL (5,0) -> cmd_err pulses once with no write; reset pulsed at CLEAR cycle 10 -> wEn stops, and after release the sweep restarts at addr 0.
